regfile_mp: RTL and testbench

Parametrised multi-port register file for the single-cycle and upcoming pipelined MIPS datapath. Configurable data width, depth, read-port count and two write ports. Asynchronous-reset clearing of the whole array, plus a software-requested sequential clear sweep with busy/done handshake. Sits in the decode stage between the instruction decoder and the ALU operand muxes.

---
 rtl/regfile_pkg.sv | 16 +
 rtl/regfile_clear_fsm.sv | 64 ++++++
 rtl/regfile_mp.sv | 88 ++++++++
 tb/tb_regfile_mp.sv | 313 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/regfile_pkg.sv
// Shared types and constants for the multi-port register file.
// Optional write-to-read forwarding is enabled with `define REGFILE_BYPASS_EN.
package regfile_pkg;

  localparam int unsigned DefDataW = 32;
  localparam int unsigned DefAddrW = 5;
  localparam int unsigned MaxDataW = 64;

  localparam logic [MaxDataW-1:0] RstVal = '0;

  typedef enum logic {
    StIdle,
    StClear
  } clear_state_e;

endpackage

// File: rtl/regfile_clear_fsm.sv
// Sequential clear sweep controller: walks a pointer over every entry, one per cycle,
// and pulses o_clear_done for one cycle once the last entry has been cleared.
module regfile_clear_fsm
  import regfile_pkg::*;
#(
  parameter int unsigned ADDR_W = DefAddrW
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              i_clear_req,
  output logic              o_busy,
  output logic              o_clear_done,
  output logic              o_clear_en,
  output logic [ADDR_W-1:0] o_clear_addr
);

  localparam logic [ADDR_W-1:0] PtrOne  = {{(ADDR_W-1){1'b0}}, 1'b1};
  localparam logic [ADDR_W-1:0] PtrLast = {ADDR_W{1'b1}};

  clear_state_e      r_state, w_state_nxt;
  logic [ADDR_W-1:0] r_ptr, w_ptr_nxt;
  logic              r_done, w_done_nxt;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_state <= StIdle;
      r_ptr   <= '0;
      r_done  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_ptr   <= w_ptr_nxt;
      r_done  <= w_done_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_ptr_nxt   = r_ptr;
    w_done_nxt  = 1'b0;
    unique case (r_state)
      StIdle: begin
        if (i_clear_req) begin
          w_state_nxt = StClear;
          w_ptr_nxt   = '0;
        end
      end
      StClear: begin
        // Pointer wraps back to 0 on the last entry; the sweep never restarts itself.
        w_ptr_nxt = r_ptr + PtrOne;
        if (r_ptr == PtrLast) begin
          w_state_nxt = StIdle;
          w_done_nxt  = 1'b1;
        end
      end
      default: w_state_nxt = StIdle;
    endcase
  end

  assign o_busy       = (r_state == StClear);
  assign o_clear_en   = (r_state == StClear);
  assign o_clear_addr = r_ptr;
  assign o_clear_done = r_done;

endmodule

// File: rtl/regfile_mp.sv
// Multi-port register file: NUM_RD combinational read ports, two write ports (port 1 wins),
// async clear on reset and a software-requested sweep clear. Macro: REGFILE_BYPASS_EN.
module regfile_mp
  import regfile_pkg::*;
#(
  parameter int unsigned DATA_W    = DefDataW,
  parameter int unsigned ADDR_W    = DefAddrW,
  parameter int unsigned NUM_RD    = 2,
  parameter int unsigned ZERO_REG0 = 1
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     WriteEnable0,
  input  logic [ADDR_W-1:0]        WriteReg0,
  input  logic [DATA_W-1:0]        WriteData0,
  input  logic                     WriteEnable1,
  input  logic [ADDR_W-1:0]        WriteReg1,
  input  logic [DATA_W-1:0]        WriteData1,
  input  logic [NUM_RD*ADDR_W-1:0] ReadReg,
  output logic [NUM_RD*DATA_W-1:0] ReadData,
  input  logic                     ClearReq,
  output logic                     Busy,
  output logic                     ClearDone
);

  localparam int unsigned DEPTH = 2 ** ADDR_W;
  localparam logic [DATA_W-1:0] EntryRst = RstVal[DATA_W-1:0];

  logic [DATA_W-1:0] r_mem [DEPTH];

  logic              w_busy;
  logic              w_idle;
  logic              w_clear_en;
  logic [ADDR_W-1:0] w_clear_addr;
  logic              w_wr0_ok;
  logic              w_wr1_ok;

  regfile_clear_fsm #(
    .ADDR_W (ADDR_W)
  ) u_clear_fsm (
    .clock        (clock),
    .reset        (reset),
    .i_clear_req  (ClearReq),
    .o_busy       (w_busy),
    .o_clear_done (ClearDone),
    .o_clear_en   (w_clear_en),
    .o_clear_addr (w_clear_addr)
  );

  assign Busy   = w_busy;
  assign w_idle = !w_busy;

  assign w_wr0_ok = w_idle && WriteEnable0 && !((ZERO_REG0 != 0) && (WriteReg0 == '0));
  assign w_wr1_ok = w_idle && WriteEnable1 && !((ZERO_REG0 != 0) && (WriteReg1 == '0));

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        r_mem[i] <= EntryRst;
      end
    end else if (w_clear_en) begin
      r_mem[w_clear_addr] <= EntryRst;
    end else begin
      // Port 1 is assigned last so it wins on an address collision.
      if (w_wr0_ok) r_mem[WriteReg0] <= WriteData0;
      if (w_wr1_ok) r_mem[WriteReg1] <= WriteData1;
    end
  end

  for (genvar k = 0; k < NUM_RD; k++) begin : g_rd
    logic [ADDR_W-1:0] w_addr;
    logic [DATA_W-1:0] w_data;

    assign w_addr = ReadReg[k*ADDR_W +: ADDR_W];

    always_comb begin
      w_data = r_mem[w_addr];
`ifdef REGFILE_BYPASS_EN
      if (w_wr0_ok && (WriteReg0 == w_addr)) w_data = WriteData0;
      if (w_wr1_ok && (WriteReg1 == w_addr)) w_data = WriteData1;
`endif
      if ((ZERO_REG0 != 0) && (w_addr == '0)) w_data = '0;
    end

    assign ReadData[k*DATA_W +: DATA_W] = w_data;
  end

endmodule

// File: tb/tb_regfile_mp.sv
// Randomised self-checking bench for regfile_mp against an array-based reference model.
module tb_regfile_mp;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        WriteEnable0 = 1'b0;
  logic [4:0]  WriteReg0 = '0;
  logic [31:0] WriteData0 = '0;
  logic        WriteEnable1 = 1'b0;
  logic [4:0]  WriteReg1 = '0;
  logic [31:0] WriteData1 = '0;
  logic [9:0]  ReadReg = '0;
  logic [63:0] ReadData;
  logic        ClearReq = 1'b0;
  logic        Busy;
  logic        ClearDone;

  int checks = 0;
  int errors = 0;

  // Reference model
  logic [31:0] m_mem [32];
  bit          m_sweep = 1'b0;
  int          m_idx   = 0;
  bit          m_done  = 1'b0;

  always #5 clock = ~clock;

  regfile_mp #(
    .DATA_W    (32),
    .ADDR_W    (5),
    .NUM_RD    (2),
    .ZERO_REG0 (1)
  ) dut (
    .clock        (clock),
    .reset        (reset),
    .WriteEnable0 (WriteEnable0),
    .WriteReg0    (WriteReg0),
    .WriteData0   (WriteData0),
    .WriteEnable1 (WriteEnable1),
    .WriteReg1    (WriteReg1),
    .WriteData1   (WriteData1),
    .ReadReg      (ReadReg),
    .ReadData     (ReadData),
    .ClearReq     (ClearReq),
    .Busy         (Busy),
    .ClearDone    (ClearDone)
  );

  function automatic logic [31:0] exp_rd(input logic [4:0] a);
    if (a == 5'd0) return 32'h0;
`ifdef REGFILE_BYPASS_EN
    if (!m_sweep && WriteEnable1 && WriteReg1 == a) return WriteData1;
    if (!m_sweep && WriteEnable0 && WriteReg0 == a) return WriteData0;
`endif
    return m_mem[a];
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 32; i++) m_mem[i] = 32'h0;
    m_sweep = 1'b0;
    m_idx   = 0;
    m_done  = 1'b0;
  endtask

  // One clock edge; the model follows the behavioural rules, then outputs settle.
  task automatic tick();
    @(posedge clock);
    if (m_sweep) begin
      m_mem[m_idx] = 32'h0;
      m_idx++;
      m_done = 1'b0;
      if (m_idx == 32) begin
        m_sweep = 1'b0;
        m_done  = 1'b1;
      end
    end else begin
      m_done = 1'b0;
      if (WriteEnable0 && WriteReg0 != 5'd0) m_mem[WriteReg0] = WriteData0;
      if (WriteEnable1 && WriteReg1 != 5'd0) m_mem[WriteReg1] = WriteData1;
      if (ClearReq) begin
        m_sweep = 1'b1;
        m_idx   = 0;
      end
    end
    #1;
  endtask

  task automatic idle_inputs();
    WriteEnable0 = 1'b0;
    WriteEnable1 = 1'b0;
    ClearReq     = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    model_reset();
    #7;
    @(negedge clock);
    reset = 1'b0;
    for (int a = 0; a < 32; a++) begin
      ReadReg = {5'(31 - a), 5'(a)};
      #1;
      checks++;
      if (ReadData !== 64'h0) begin
        errors++;
        $display("FAIL reset_read addr %0d: got %h expected 0", a, ReadData);
      end
    end
    checks++;
    if (Busy !== 1'b0 || ClearDone !== 1'b0) begin
      errors++;
      $display("FAIL reset_flags: Busy=%b ClearDone=%b expected 0/0", Busy, ClearDone);
    end
  endtask

  task automatic test_write_read();
    idle_inputs();
    WriteEnable0 = 1'b1; WriteReg0 = 5'd5; WriteData0 = 32'hDEADBEEF;
    tick();
    idle_inputs();
    ReadReg = {5'd0, 5'd5};
    #1;
    checks++;
    if (ReadData[31:0] !== 32'hDEADBEEF) begin
      errors++;
      $display("FAIL write_reg5: got %h expected deadbeef", ReadData[31:0]);
    end
    WriteEnable0 = 1'b1; WriteReg0 = 5'd0; WriteData0 = 32'h1234;
    WriteEnable1 = 1'b1; WriteReg1 = 5'd0; WriteData1 = 32'h5678;
    tick();
    idle_inputs();
    ReadReg = {5'd0, 5'd0};
    #1;
    checks++;
    if (ReadData !== 64'h0) begin
      errors++;
      $display("FAIL zero_reg0: got %h expected 0", ReadData);
    end
  endtask

  task automatic test_same_addr();
    idle_inputs();
    WriteEnable0 = 1'b1; WriteReg0 = 5'd7; WriteData0 = 32'h11;
    WriteEnable1 = 1'b1; WriteReg1 = 5'd7; WriteData1 = 32'h22;
    tick();
    idle_inputs();
    ReadReg = {5'd7, 5'd7};
    #1;
    checks++;
    if (ReadData !== {32'h22, 32'h22}) begin
      errors++;
      $display("FAIL same_addr_reg7: got %h expected 22 on both ports", ReadData);
    end
  endtask

  task automatic test_bypass();
    idle_inputs();
    WriteEnable0 = 1'b1; WriteReg0 = 5'd9; WriteData0 = 32'h77;
    tick();
    WriteData0 = 32'h55;
    ReadReg    = {5'd0, 5'd9};
    #1;
    checks++;
`ifdef REGFILE_BYPASS_EN
    if (ReadData[31:0] !== 32'h55) begin
      errors++;
      $display("FAIL bypass_same_cycle: got %h expected 55", ReadData[31:0]);
    end
`else
    if (ReadData[31:0] !== 32'h77) begin
      errors++;
      $display("FAIL no_bypass_same_cycle: got %h expected 77", ReadData[31:0]);
    end
`endif
    tick();
    idle_inputs();
    #1;
    checks++;
    if (ReadData[31:0] !== 32'h55) begin
      errors++;
      $display("FAIL write_next_cycle: got %h expected 55", ReadData[31:0]);
    end
  endtask

  task automatic test_random();
    logic [4:0] a0, a1;
    for (int c = 0; c < 300; c++) begin
      WriteEnable0 = 1'($urandom);
      WriteReg0    = 5'($urandom);
      WriteData0   = $urandom;
      WriteEnable1 = 1'($urandom);
      WriteReg1    = ($urandom_range(0, 3) == 0) ? WriteReg0 : 5'($urandom);
      WriteData1   = $urandom;
      a0 = ($urandom_range(0, 2) == 0) ? WriteReg0 : 5'($urandom);
      a1 = ($urandom_range(0, 2) == 0) ? WriteReg1 : 5'($urandom);
      ReadReg = {a1, a0};
      #1;
      checks++;
      if (ReadData !== {exp_rd(a1), exp_rd(a0)}) begin
        errors++;
        $display("FAIL random_read cycle %0d addr %0d/%0d: got %h expected %h%h",
                 c, a1, a0, ReadData, exp_rd(a1), exp_rd(a0));
      end
      tick();
    end
    idle_inputs();
  endtask

  task automatic test_clear_sweep();
    int busy_n = 0;
    int done_n = 0;
    for (int i = 1; i < 32; i++) begin
      WriteEnable0 = 1'b1; WriteReg0 = 5'(i); WriteData0 = 32'(i);
      tick();
    end
    // Write committed in the same cycle as the request, then swept away.
    WriteEnable0 = 1'b1; WriteReg0 = 5'd4; WriteData0 = 32'h4444;
    ClearReq = 1'b1;
    tick();
    idle_inputs();
    for (int c = 0; c < 40; c++) begin
      checks++;
      if (Busy !== m_sweep || ClearDone !== m_done) begin
        errors++;
        $display("FAIL sweep_flags cycle %0d: Busy=%b ClearDone=%b expected %b/%b",
                 c, Busy, ClearDone, m_sweep, m_done);
      end
      if (Busy === 1'b1) busy_n++;
      if (ClearDone === 1'b1) done_n++;
      WriteEnable0 = (c == 10);
      WriteReg0    = 5'd3;
      WriteData0   = 32'hAA;
      ReadReg      = {5'd3, 5'(c)};
      #1;
      checks++;
      if (ReadData !== {exp_rd(5'd3), exp_rd(5'(c))}) begin
        errors++;
        $display("FAIL sweep_read cycle %0d: got %h expected %h%h",
                 c, ReadData, exp_rd(5'd3), exp_rd(5'(c)));
      end
      tick();
    end
    idle_inputs();
    checks++;
    if (busy_n != 32 || done_n != 1) begin
      errors++;
      $display("FAIL sweep_length: busy cycles %0d done pulses %0d expected 32/1", busy_n, done_n);
    end
    for (int a = 0; a < 32; a++) begin
      ReadReg = {5'(a), 5'(a)};
      #1;
      checks++;
      if (ReadData !== 64'h0) begin
        errors++;
        $display("FAIL sweep_cleared addr %0d: got %h expected 0", a, ReadData);
      end
    end
  endtask

  task automatic test_reset_mid_sweep();
    for (int i = 1; i < 32; i += 3) begin
      WriteEnable1 = 1'b1; WriteReg1 = 5'(i); WriteData1 = $urandom | 32'h1;
      tick();
    end
    idle_inputs();
    ClearReq = 1'b1;
    tick();
    ClearReq = 1'b0;
    for (int c = 0; c < 10; c++) tick();
    reset = 1'b1;
    model_reset();
    #1;
    checks++;
    if (Busy !== 1'b0 || ClearDone !== 1'b0) begin
      errors++;
      $display("FAIL mid_sweep_reset_flags: Busy=%b ClearDone=%b expected 0/0", Busy, ClearDone);
    end
    @(negedge clock);
    reset = 1'b0;
    for (int c = 0; c < 3; c++) begin
      tick();
      checks++;
      if (ClearDone !== 1'b0 || Busy !== 1'b0) begin
        errors++;
        $display("FAIL mid_sweep_no_done cycle %0d: Busy=%b ClearDone=%b expected 0/0",
                 c, Busy, ClearDone);
      end
    end
    for (int a = 0; a < 32; a++) begin
      ReadReg = {5'(a), 5'(a)};
      #1;
      checks++;
      if (ReadData !== 64'h0) begin
        errors++;
        $display("FAIL mid_sweep_zeroed addr %0d: got %h expected 0", a, ReadData);
      end
    end
  endtask

  initial begin
    test_reset();
    test_write_read();
    test_same_addr();
    test_bypass();
    test_random();
    test_clear_sweep();
    test_reset_mid_sweep();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
